// File: rtl/sdram_xfer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_xfer_pkg                                                       |
// | Shared types and width helpers for the SDRAM transfer sequencer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sdram_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } xfer_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_LEN      = 2'd1;
  localparam logic [1:0] ERR_SPURIOUS = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_xfer_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_xfer_buf                                                       |
// | Simple dual-port word buffer: one write port, one registered read.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_xfer_buf
  import sdram_xfer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [idx_width(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          re,
  input  logic [idx_width(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]             rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sdram_xfer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_xfer_seq                                                       |
// | Multi-word SDRAM burst sequencer between host buffers and the        |
// | controller. Optional watchdog: define SDRAM_XFER_TIMEOUT_EN.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_xfer_seq
  import sdram_xfer_pkg::*;
#(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 22,
  parameter int BUF_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_wr,
  input  logic [ADDR_W-1:0]                 cmd_addr,
  input  logic [idx_width(BUF_DEPTH):0]     cmd_len,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  input  logic                              wbuf_we,
  input  logic [idx_width(BUF_DEPTH)-1:0]   wbuf_addr,
  input  logic [DATA_W-1:0]                 wbuf_data,
  input  logic [idx_width(BUF_DEPTH)-1:0]   rbuf_addr,
  output logic [DATA_W-1:0]                 rbuf_data,
  output logic                              sdram_req,
  input  logic                              sdram_ack,
  output logic                              sdram_wr,
  output logic [ADDR_W-1:0]                 sdram_addr,
  output logic [DATA_W-1:0]                 sdram_wr_data,
  input  logic                              sdram_rd_ack,
  input  logic [DATA_W-1:0]                 sdram_rd_data
);

  localparam int IDX_W = idx_width(BUF_DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sdram_xfer_seq: BUF_DEPTH must be a power of two >= 2");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_chk_outstanding
    $error("sdram_xfer_seq: MAX_OUTSTANDING must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("sdram_xfer_seq: TIMEOUT_CYCLES must be >= 1");
  end

  xfer_state_e        r_state;
  logic               r_req;
  logic               r_wr;
  logic               r_busy;
  logic               r_done;
  logic [1:0]         r_err_cause;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_issue_idx;
  logic [LEN_W-1:0]   r_ret_idx;
  logic [CNT_W-1:0]   r_outstanding;

  logic               w_accept;
  logic               w_len_bad;
  logic               w_ack;
  logic               w_last_ack;
  logic               w_xfer_active;
  logic               w_ret_ok;
  logic               w_ret_bad;
  logic               w_ret_last;
  logic               w_timeout;
  logic [CNT_W-1:0]   w_out_next;
  logic               w_wbuf_re;
  logic [IDX_W-1:0]   w_wbuf_raddr;

  assign w_accept      = cmd_valid && !r_busy;
  assign w_len_bad     = (cmd_len == '0) || (cmd_len > LEN_W'(BUF_DEPTH));
  assign w_ack         = sdram_ack && r_req && (r_state == ISSUE);
  assign w_last_ack    = w_ack && (r_issue_idx == r_len - LEN_W'(1));
  assign w_xfer_active = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_ret_ok      = sdram_rd_ack && w_xfer_active && !r_wr && (r_outstanding != '0);
  assign w_ret_bad     = sdram_rd_ack && w_xfer_active && !w_ret_ok;
  assign w_ret_last    = w_ret_ok && ((r_ret_idx + LEN_W'(1)) == r_len);

  always_comb begin
    w_out_next = r_outstanding;
    if (w_ack && !r_wr && !w_ret_ok) begin
      w_out_next = r_outstanding + CNT_W'(1);
    end else if (!(w_ack && !r_wr) && w_ret_ok) begin
      w_out_next = r_outstanding - CNT_W'(1);
    end
  end

  // Prefetch the next write word so its data is ready the cycle req is shown.
  assign w_wbuf_re    = (w_accept && cmd_wr) || (w_ack && r_wr);
  assign w_wbuf_raddr = w_accept ? '0 : (r_issue_idx[IDX_W-1:0] + IDX_W'(1));

`ifdef SDRAM_XFER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (reset || !w_xfer_active || sdram_ack || sdram_rd_ack) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign w_timeout = w_xfer_active && !sdram_ack && !sdram_rd_ack &&
                     (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_req         <= 1'b0;
      r_wr          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_cause   <= ERR_NONE;
      r_addr        <= '0;
      r_len         <= '0;
      r_issue_idx   <= '0;
      r_ret_idx     <= '0;
      r_outstanding <= '0;
    end else begin
      r_done        <= 1'b0;
      r_outstanding <= w_out_next;
      if (w_ack) begin
        r_issue_idx <= r_issue_idx + LEN_W'(1);
        r_addr      <= r_addr + ADDR_W'(1);
      end
      if (w_ret_ok) begin
        r_ret_idx <= r_ret_idx + LEN_W'(1);
      end
      if (w_ret_bad && r_err_cause == ERR_NONE) begin
        r_err_cause <= ERR_SPURIOUS;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_len         <= cmd_len;
            r_wr          <= cmd_wr;
            r_addr        <= cmd_addr;
            r_issue_idx   <= '0;
            r_ret_idx     <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b1;
            if (w_len_bad) begin
              r_err_cause <= ERR_LEN;
              r_state     <= FIN;
              r_done      <= 1'b1;
            end else begin
              r_err_cause <= ERR_NONE;
              r_state     <= ISSUE;
              r_req       <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_timeout) begin
            r_req       <= 1'b0;
            r_err_cause <= ERR_TIMEOUT;
            r_state     <= FIN;
            r_done      <= 1'b1;
          end else if (w_last_ack) begin
            r_req <= 1'b0;
            if (r_wr) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end else begin
            // Reads stall while the controller holds the maximum in flight.
            r_req <= r_wr || (w_out_next != CNT_W'(MAX_OUTSTANDING));
          end
        end
        DRAIN: begin
          if (w_timeout) begin
            r_err_cause <= ERR_TIMEOUT;
            r_state     <= FIN;
            r_done      <= 1'b1;
          end else if (w_ret_last) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sdram_xfer_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_wbuf (
    .clk   (clk),
    .reset (reset),
    .we    (wbuf_we),
    .waddr (wbuf_addr),
    .wdata (wbuf_data),
    .re    (w_wbuf_re),
    .raddr (w_wbuf_raddr),
    .rdata (sdram_wr_data)
  );

  sdram_xfer_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_rbuf (
    .clk   (clk),
    .reset (reset),
    .we    (w_ret_ok),
    .waddr (r_ret_idx[IDX_W-1:0]),
    .wdata (sdram_rd_data),
    .re    (1'b1),
    .raddr (rbuf_addr),
    .rdata (rbuf_data)
  );

  assign cmd_ready  = !r_busy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = (r_err_cause != ERR_NONE);
  assign sdram_req  = r_req;
  assign sdram_wr   = r_wr;
  assign sdram_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_sdram_xfer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdram_xfer_seq                                                    |
// | Directed self-checking bench for sdram_xfer_seq.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sdram_xfer_seq;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [4:0]        cmd_len;
  logic              busy, done, err;
  logic              wbuf_we;
  logic [3:0]        wbuf_addr, rbuf_addr;
  logic [DATA_W-1:0] wbuf_data, rbuf_data;
  logic              sdram_req, sdram_ack, sdram_wr, sdram_rd_ack;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_wr_data, sdram_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  int                req_cyc  [128];
  logic [ADDR_W-1:0] req_addr [128];
  logic [DATA_W-1:0] req_data [128];
  logic              req_wr   [128];
  int                req_n;
  int                done_cyc;
  logic              done_err;
  bit                svc_finished;

  sdram_xfer_seq #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(16),
    .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .wbuf_we(wbuf_we), .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data),
    .rbuf_addr(rbuf_addr), .rbuf_data(rbuf_data),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_wr(sdram_wr),
    .sdram_addr(sdram_addr), .sdram_wr_data(sdram_wr_data),
    .sdram_rd_ack(sdram_rd_ack), .sdram_rd_data(sdram_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Called at a negedge with cmd_ready high; returns at the negedge of cycle T+1.
  task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [4:0] l);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic fill_wbuf(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      wbuf_we   = 1'b1;
      wbuf_addr = 4'(i);
      wbuf_data = base + DATA_W'(i);
      @(negedge clk);
    end
    wbuf_we = 1'b0;
  endtask

  // Controller model: records requests, acks per ack_en, returns reads after ret_delay.
  task automatic service(input bit ack_en, input int ret_delay, input int spur_cyc, input int max_cycles);
    int                due_q [$];
    logic [DATA_W-1:0] dat_q [$];
    req_n = 0; done_cyc = 0; done_err = 1'b0; svc_finished = 1'b0;
    for (int c = 1; c <= max_cycles; c++) begin
      if (done === 1'b1) begin
        done_cyc = c; done_err = err; svc_finished = 1'b1;
        break;
      end
      if (sdram_req === 1'b1 && req_n < 128) begin
        req_cyc[req_n]  = c;
        req_addr[req_n] = sdram_addr;
        req_data[req_n] = sdram_wr_data;
        req_wr[req_n]   = sdram_wr;
        req_n++;
      end
      sdram_ack = (sdram_req === 1'b1) && ack_en;
      if (sdram_ack && sdram_wr === 1'b0) begin
        due_q.push_back(c + ret_delay);
        dat_q.push_back(64'hDEAD_0000_0000_0000 + DATA_W'(sdram_addr));
      end
      if (due_q.size() > 0 && due_q[0] <= c) begin
        sdram_rd_ack  = 1'b1;
        sdram_rd_data = dat_q.pop_front();
        void'(due_q.pop_front());
      end else if (c == spur_cyc) begin
        sdram_rd_ack  = 1'b1;
        sdram_rd_data = '1;
      end else begin
        sdram_rd_ack = 1'b0;
      end
      @(negedge clk);
    end
    sdram_ack    = 1'b0;
    sdram_rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_checks++; if (sdram_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", sdram_req); end
    n_checks++; if (sdram_wr !== 1'b0) begin n_errors++; $display("FAIL reset_wr: got %b want 0", sdram_wr); end
    n_checks++; if (sdram_addr !== '0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", sdram_addr); end
    n_checks++; if (sdram_wr_data !== '0) begin n_errors++; $display("FAIL reset_wr_data: got %h want 0", sdram_wr_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    fill_wbuf(8, 64'h1000);
    drive_cmd(1'b1, 22'h100, 5'd8);
    n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL write_accept: busy %b ready %b want 1 0", busy, cmd_ready); end
    service(1'b1, 0, 0, 50);
    n_checks++; if (!svc_finished) begin n_errors++; $display("FAIL write_done_seen: no done within 50 cycles want done"); end
    n_checks++; if (req_n !== 8) begin n_errors++; $display("FAIL write_req_count: got %0d want 8", req_n); end
    for (int i = 0; i < 8; i++) begin
      ea = 22'h100 + ADDR_W'(i);
      ed = 64'h1000 + DATA_W'(i);
      n_checks++;
      if (req_addr[i] !== ea || req_data[i] !== ed || req_wr[i] !== 1'b1 || req_cyc[i] !== i + 1) begin
        n_errors++;
        $display("FAIL write_req%0d: got addr %h data %h wr %b cyc %0d want %h %h 1 %0d",
                 i, req_addr[i], req_data[i], req_wr[i], req_cyc[i], ea, ed, i + 1);
      end
    end
    n_checks++; if (done_cyc !== 9) begin n_errors++; $display("FAIL write_done_cycle: got %0d want 9", done_cyc); end
    n_checks++; if (done_err !== 1'b0) begin n_errors++; $display("FAIL write_err: got %b want 0", done_err); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL write_idle: busy %b ready %b want 0 1", busy, cmd_ready); end
  endtask

  task automatic test_read_throttle();
    int                exp_cyc [8];
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    exp_cyc = '{1, 2, 3, 4, 12, 13, 14, 15};
    drive_cmd(1'b0, 22'h200, 5'd8);
    service(1'b1, 10, 0, 100);
    n_checks++; if (!svc_finished) begin n_errors++; $display("FAIL rd_done_seen: no done within 100 cycles want done"); end
    n_checks++; if (req_n !== 8) begin n_errors++; $display("FAIL rd_req_count: got %0d want 8", req_n); end
    for (int i = 0; i < 8; i++) begin
      ea = 22'h200 + ADDR_W'(i);
      n_checks++;
      if (req_addr[i] !== ea || req_wr[i] !== 1'b0 || req_cyc[i] !== exp_cyc[i]) begin
        n_errors++;
        $display("FAIL rd_req%0d: got addr %h wr %b cyc %0d want %h 0 %0d",
                 i, req_addr[i], req_wr[i], req_cyc[i], ea, exp_cyc[i]);
      end
    end
    n_checks++; if (done_cyc !== 26) begin n_errors++; $display("FAIL rd_done_cycle: got %0d want 26", done_cyc); end
    n_checks++; if (done_err !== 1'b0) begin n_errors++; $display("FAIL rd_err: got %b want 0", done_err); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rbuf_addr = 4'(i);
      @(negedge clk);
      ed = 64'hDEAD_0000_0000_0000 + DATA_W'(22'h200 + ADDR_W'(i));
      n_checks++; if (rbuf_data !== ed) begin n_errors++; $display("FAIL rd_buf%0d: got %h want %h", i, rbuf_data, ed); end
    end
  endtask

  task automatic test_reset_mid_read();
    drive_cmd(1'b0, 22'h300, 5'd8);
    service(1'b1, 10, 0, 3);
    n_checks++; if (req_n !== 3 || sdram_req !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre: reqs %0d req %b want 3 1", req_n, sdram_req); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (sdram_req !== 1'b0) begin n_errors++; $display("FAIL rst_mid_req: got %b want 0", sdram_req); end
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_status: busy %b ready %b done %b err %b want 0 1 0 0", busy, cmd_ready, done, err);
    end
    n_checks++; if (sdram_addr !== '0) begin n_errors++; $display("FAIL rst_mid_addr: got %h want 0", sdram_addr); end
    for (int k = 0; k < 3; k++) begin
      sdram_rd_ack  = 1'b1;
      sdram_rd_data = 64'hBAD0 + DATA_W'(k);
      @(negedge clk);
      sdram_rd_ack = 1'b0;
      n_checks++; if (busy !== 1'b0 || err !== 1'b0 || sdram_req !== 1'b0 || done !== 1'b0) begin
        n_errors++; $display("FAIL rst_stray%0d: busy %b err %b req %b done %b want 0 0 0 0", k, busy, err, sdram_req, done);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};
    drive_cmd(1'b0, 22'h3FFFFE, 5'd4);
    service(1'b1, 2, 0, 50);
    n_checks++; if (!svc_finished || done_cyc !== 7) begin n_errors++; $display("FAIL wrap_done: finished %b cyc %0d want 1 7", svc_finished, done_cyc); end
    n_checks++; if (req_n !== 4) begin n_errors++; $display("FAIL wrap_req_count: got %0d want 4", req_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (req_addr[i] !== exp_a[i]) begin n_errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, req_addr[i], exp_a[i]); end
    end
    n_checks++; if (done_err !== 1'b0) begin n_errors++; $display("FAIL wrap_err: got %b want 0", done_err); end
    @(negedge clk);
    rbuf_addr = 4'd2;
    @(negedge clk);
    n_checks++; if (rbuf_data !== 64'hDEAD_0000_0000_0000) begin n_errors++; $display("FAIL wrap_buf2: got %h want dead000000000000", rbuf_data); end
  endtask

  task automatic test_bad_len();
    logic [4:0] lens [2];
    lens = '{5'd0, 5'd17};
    for (int j = 0; j < 2; j++) begin
      drive_cmd(1'b0, 22'h10, lens[j]);
      service(1'b1, 2, 0, 10);
      n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL badlen%0d_done_cycle: got %0d want 1", lens[j], done_cyc); end
      n_checks++; if (done_err !== 1'b1) begin n_errors++; $display("FAIL badlen%0d_err: got %b want 1", lens[j], done_err); end
      n_checks++; if (req_n !== 0 || sdram_req !== 1'b0) begin n_errors++; $display("FAIL badlen%0d_req: reqs %0d req %b want 0 0", lens[j], req_n, sdram_req); end
      @(negedge clk);
    end
  endtask

  task automatic test_spurious();
    fill_wbuf(2, 64'h5000);
    drive_cmd(1'b1, 22'h50, 5'd2);
    service(1'b1, 0, 1, 20);
    n_checks++; if (done_cyc !== 3 || done_err !== 1'b1) begin n_errors++; $display("FAIL spur_wr: cyc %0d err %b want 3 1", done_cyc, done_err); end
    @(negedge clk);
    n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL spur_wr_hold: err %b busy %b want 1 0", err, busy); end
    drive_cmd(1'b0, 22'h60, 5'd1);
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL spur_err_clear: got %b want 0", err); end
    service(1'b1, 3, 1, 20);
    n_checks++; if (done_cyc !== 5 || done_err !== 1'b1) begin n_errors++; $display("FAIL spur_rd: cyc %0d err %b want 5 1", done_cyc, done_err); end
    @(negedge clk);
  endtask

`ifdef SDRAM_XFER_TIMEOUT_EN
  task automatic test_watchdog();
    drive_cmd(1'b1, 22'h70, 5'd2);
    service(1'b0, 0, 0, 200);
    n_checks++; if (!svc_finished || done_cyc !== 65) begin n_errors++; $display("FAIL wdog_done: finished %b cyc %0d want 1 65", svc_finished, done_cyc); end
    n_checks++; if (done_err !== 1'b1) begin n_errors++; $display("FAIL wdog_err: got %b want 1", done_err); end
    n_checks++; if (sdram_req !== 1'b0 || req_n !== 64) begin n_errors++; $display("FAIL wdog_req: req %b reqcycles %0d want 0 64", sdram_req, req_n); end
    sdram_rd_ack = 1'b1;
    @(negedge clk);
    sdram_rd_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || err !== 1'b1 || sdram_req !== 1'b0) begin n_errors++; $display("FAIL wdog_after: busy %b err %b req %b want 0 1 0", busy, err, sdram_req); end
  endtask
`endif

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wbuf_we = 1'b0; wbuf_addr = '0; wbuf_data = '0; rbuf_addr = '0;
    sdram_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rd_data = '0;
    test_reset();
    test_write();
    test_read_throttle();
    test_reset_mid_read();
    test_addr_wrap();
    test_bad_len();
    test_spurious();
`ifdef SDRAM_XFER_TIMEOUT_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
